// File: rtl/fifo_hist_monitor.sv
// Per-channel FIFO write monitor: write-gap and fill-level histograms behind a
// registered read port. Define HIST_MON_CLR_ON_READ_EN for clear-on-read bins.
module fifo_hist_monitor #(
   parameter int                NUM_CH      = 2,
   parameter int                NUM_BINS    = 16,
   parameter int                BIN_RANGE   = 8,
   parameter int                CNT_W       = 16,
   parameter int                GAP_W       = 16,
   parameter int                LVL_W       = 16,
   parameter logic [NUM_CH-1:0] WR_DIV_MASK = NUM_CH'(2'b10),
   localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int               BIN_W       = $clog2(NUM_BINS),
   localparam int               ADDR_W      = CH_W + 1 + BIN_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run_program,
   input  logic                      active_program,
   input  logic                      end_program,
   input  logic [NUM_CH-1:0]         fifo_wr,
   input  logic [NUM_CH*LVL_W-1:0]   fifo_lvl,
   input  logic                      rd_en,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [CNT_W-1:0]          rd_data,
   output logic                      rd_valid,
   output logic [NUM_CH*GAP_W-1:0]   gap_cnt,
   output logic [NUM_CH*32-1:0]      words_written,
   output logic [NUM_CH-1:0]         sat_flag
);

   localparam int RANGE_SH = $clog2(BIN_RANGE);

   // Bin i covers (i*R, (i+1)*R]; zero lands in bin 0 and the top bin is open-ended.
   function automatic logic [BIN_W-1:0] bin_of(input logic [31:0] value);
      logic [31:0] idx;
      idx = (value - 32'd1) >> RANGE_SH;
      if (value == 32'd0) return '0;
      if (idx > 32'(NUM_BINS - 1)) return BIN_W'(NUM_BINS - 1);
      return idx[BIN_W-1:0];
   endfunction

   logic                start;
   logic                clear_stats;
   logic [NUM_CH-1:0]   phase;
   logic [NUM_CH-1:0]   first_seen;
   logic [NUM_CH-1:0]   sat;
   logic [NUM_CH-1:0]   word_wr;
   logic [NUM_CH-1:0]   update;
   logic [NUM_CH-1:0]   sat_hit;
   logic [GAP_W-1:0]    gap_val   [NUM_CH];
   logic [31:0]         word_cnt  [NUM_CH];
   logic [CNT_W-1:0]    gap_bins  [NUM_CH][NUM_BINS];
   logic [CNT_W-1:0]    fill_bins [NUM_CH][NUM_BINS];
   logic [BIN_W-1:0]    gap_bin   [NUM_CH];
   logic [BIN_W-1:0]    fill_bin  [NUM_CH];
   logic [NUM_BINS-1:0] gap_inc   [NUM_CH];
   logic [NUM_BINS-1:0] fill_inc  [NUM_CH];
   logic [NUM_BINS-1:0] gap_clr   [NUM_CH];
   logic [NUM_BINS-1:0] fill_clr  [NUM_CH];
   logic [CH_W-1:0]     rd_ch;
   logic                rd_type;
   logic [BIN_W-1:0]    rd_bin;
   logic [CNT_W-1:0]    rd_sel;

   assign start       = run_program && !active_program;
   assign clear_stats = !reset || start;

   assign rd_ch   = rd_addr[ADDR_W-1 -: CH_W];
   assign rd_type = rd_addr[BIN_W];
   assign rd_bin  = rd_addr[BIN_W-1:0];

   // The update uses the registered first_seen, so the opening word of a program only arms the channel.
   always_comb begin
      word_wr = '0;
      update  = '0;
      sat_hit = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         gap_bin[c]  = bin_of(32'(gap_val[c]));
         fill_bin[c] = bin_of(32'(fifo_lvl[c*LVL_W +: LVL_W]));
         word_wr[c]  = fifo_wr[c] && (WR_DIV_MASK[c] ? phase[c] : 1'b1);
         update[c]   = word_wr[c] && active_program && first_seen[c];
         sat_hit[c]  = update[c] && ((gap_bins[c][gap_bin[c]] == '1) ||
                                     (fill_bins[c][fill_bin[c]] == '1));
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         gap_inc[c]  = '0;
         fill_inc[c] = '0;
         gap_clr[c]  = '0;
         fill_clr[c] = '0;
         for (int b = 0; b < NUM_BINS; b++) begin
            gap_inc[c][b]  = update[c] && (gap_bin[c] == BIN_W'(b));
            fill_inc[c][b] = update[c] && (fill_bin[c] == BIN_W'(b));
`ifdef HIST_MON_CLR_ON_READ_EN
            gap_clr[c][b]  = rd_en && (rd_ch == CH_W'(c)) && !rd_type && (rd_bin == BIN_W'(b));
            fill_clr[c][b] = rd_en && (rd_ch == CH_W'(c)) && rd_type && (rd_bin == BIN_W'(b));
`endif
         end
      end
   end

   // Channel numbers with no matching instance fall through to zero.
   always_comb begin
      rd_sel = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch == CH_W'(c)) begin
            rd_sel = rd_type ? fill_bins[c][rd_bin] : gap_bins[c][rd_bin];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear_stats) begin
         phase      <= '0;
         first_seen <= '0;
         sat        <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            gap_val[c]  <= '0;
            word_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (fifo_wr[c]) begin
               phase[c] <= ~phase[c];
            end
            if (word_wr[c] && active_program) begin
               first_seen[c] <= 1'b1;
               if (word_cnt[c] != '1) begin
                  word_cnt[c] <= word_cnt[c] + 32'd1;
               end
            end
            if (end_program || word_wr[c]) begin
               gap_val[c] <= '0;
            end else if (active_program && first_seen[c] && (gap_val[c] != '1)) begin
               gap_val[c] <= gap_val[c] + GAP_W'(1);
            end
            if (sat_hit[c]) begin
               sat[c] <= 1'b1;
            end
         end
      end
   end

   // A clear that coincides with an increment keeps that one new event.
   always_ff @(posedge clk) begin
      if (clear_stats) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < NUM_BINS; b++) begin
               gap_bins[c][b]  <= '0;
               fill_bins[c][b] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < NUM_BINS; b++) begin
               if (gap_clr[c][b]) begin
                  gap_bins[c][b] <= gap_inc[c][b] ? CNT_W'(1) : '0;
               end else if (gap_inc[c][b] && (gap_bins[c][b] != '1)) begin
                  gap_bins[c][b] <= gap_bins[c][b] + CNT_W'(1);
               end
               if (fill_clr[c][b]) begin
                  fill_bins[c][b] <= fill_inc[c][b] ? CNT_W'(1) : '0;
               end else if (fill_inc[c][b] && (fill_bins[c][b] != '1)) begin
                  fill_bins[c][b] <= fill_bins[c][b] + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= rd_sel;
         end
      end
   end

   always_comb begin
      gap_cnt       = '0;
      words_written = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         gap_cnt[c*GAP_W +: GAP_W]  = gap_val[c];
         words_written[c*32 +: 32]  = word_cnt[c];
      end
   end

   assign sat_flag = sat;

endmodule

// File: tb/tb_fifo_hist_monitor.sv
// Randomized bench for fifo_hist_monitor against a histogram model built from
// plain counters and arrays; three channels so an out-of-range channel is addressable.
module tb_fifo_hist_monitor;

   localparam int             NCH      = 3;
   localparam int             NB       = 16;
   localparam int             CW       = 4;
   localparam int             GW       = 8;
   localparam int             LW       = 16;
   localparam int             AW       = 7;
   localparam logic [NCH-1:0] DIV_MASK = 3'b010;
   localparam int             CNT_MAX  = 15;
   localparam int             GAP_MAX  = 255;

   logic                clk = 1'b0;
   logic                reset;
   logic                run_program;
   logic                active_program;
   logic                end_program;
   logic [NCH-1:0]      fifo_wr;
   logic [NCH*LW-1:0]   fifo_lvl;
   logic                rd_en;
   logic [AW-1:0]       rd_addr;
   logic [CW-1:0]       rd_data;
   logic                rd_valid;
   logic [NCH*GW-1:0]   gap_cnt;
   logic [NCH*32-1:0]   words_written;
   logic [NCH-1:0]      sat_flag;

   always #5 clk = ~clk;

   fifo_hist_monitor #(
      .NUM_CH(NCH), .NUM_BINS(NB), .BIN_RANGE(8), .CNT_W(CW),
      .GAP_W(GW), .LVL_W(LW), .WR_DIV_MASK(DIV_MASK)
   ) dut (
      .clk(clk), .reset(reset), .run_program(run_program),
      .active_program(active_program), .end_program(end_program),
      .fifo_wr(fifo_wr), .fifo_lvl(fifo_lvl), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .gap_cnt(gap_cnt),
      .words_written(words_written), .sat_flag(sat_flag)
   );

   int     checkCount = 0;
   int     errorCount = 0;
   int     mGap    [NCH][NB];
   int     mFill   [NCH][NB];
   int     mGapCnt [NCH];
   longint mWords  [NCH];
   bit     mSeen   [NCH];
   bit     mSat    [NCH];
   int     mPulses [NCH];
   bit     expRdValid = 1'b0;
   int     expRdData  = 0;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int binOf(input int v);
      if (v == 0) return 0;
      if ((v - 1) / 8 > NB - 1) return NB - 1;
      return (v - 1) / 8;
   endfunction

   task automatic modelClear();
      for (int c = 0; c < NCH; c++) begin
         mGapCnt[c] = 0;
         mWords[c]  = 0;
         mSeen[c]   = 1'b0;
         mSat[c]    = 1'b0;
         mPulses[c] = 0;
         for (int b = 0; b < NB; b++) begin
            mGap[c][b]  = 0;
            mFill[c][b] = 0;
         end
      end
   endtask

   // One clock of the reference: read sample first, then statistics, then clear-on-read.
   task automatic modelStep();
      int ch, ty, bn, gb, fb;
      bit word, seenOld;
      bit incG [NCH][NB];
      bit incF [NCH][NB];
      for (int c = 0; c < NCH; c++) begin
         for (int b = 0; b < NB; b++) begin
            incG[c][b] = 1'b0;
            incF[c][b] = 1'b0;
         end
      end
      if (!reset) begin
         modelClear();
         expRdValid = 1'b0;
         expRdData  = 0;
         return;
      end
      ch = int'(rd_addr[6:5]);
      ty = int'(rd_addr[4]);
      bn = int'(rd_addr[3:0]);
      expRdValid = rd_en;
      if (rd_en) expRdData = (ch < NCH) ? (ty != 0 ? mFill[ch][bn] : mGap[ch][bn]) : 0;
      if (run_program && !active_program) begin
         modelClear();
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         word = 1'b0;
         if (fifo_wr[c]) begin
            mPulses[c]++;
            word = DIV_MASK[c] ? (mPulses[c] % 2 == 0) : 1'b1;
         end
         seenOld = mSeen[c];
         if (word && active_program) begin
            if (seenOld) begin
               gb = binOf(mGapCnt[c]);
               fb = binOf(int'(fifo_lvl[c*LW +: LW]));
               incG[c][gb] = 1'b1;
               incF[c][fb] = 1'b1;
               if (mGap[c][gb] == CNT_MAX) mSat[c] = 1'b1; else mGap[c][gb]++;
               if (mFill[c][fb] == CNT_MAX) mSat[c] = 1'b1; else mFill[c][fb]++;
            end
            mSeen[c] = 1'b1;
            if (mWords[c] < 64'hFFFF_FFFF) mWords[c]++;
         end
         if (end_program || word) mGapCnt[c] = 0;
         else if (active_program && seenOld && mGapCnt[c] < GAP_MAX) mGapCnt[c]++;
      end
`ifdef HIST_MON_CLR_ON_READ_EN
      if (rd_en && ch < NCH) begin
         if (ty != 0) mFill[ch][bn] = incF[ch][bn] ? 1 : 0;
         else         mGap[ch][bn]  = incG[ch][bn] ? 1 : 0;
      end
`endif
   endtask

   task automatic compareAll();
      checkOutput("rd_valid", int'(rd_valid), int'(expRdValid));
      checkOutput("rd_data", int'(rd_data), expRdData);
      for (int c = 0; c < NCH; c++) begin
         checkOutput($sformatf("gap_cnt%0d", c), int'(gap_cnt[c*GW +: GW]), mGapCnt[c]);
         checkOutput($sformatf("words%0d", c), int'(words_written[c*32 +: 32]), int'(mWords[c]));
         checkOutput($sformatf("sat%0d", c), int'(sat_flag[c]), int'(mSat[c]));
      end
   endtask

   task automatic applyStimulus(input logic [NCH-1:0] wr, input logic ren, input logic [AW-1:0] addr);
      fifo_wr = wr;
      rd_en   = ren;
      rd_addr = addr;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, '0);
   endtask

   task automatic writeWord(input int c);
      applyStimulus(NCH'(1) << c, 1'b0, '0);
   endtask

   task automatic readBin(input int c, input int t, input int b);
      applyStimulus('0, 1'b1, {2'(c), 1'(t), 4'(b)});
   endtask

   task automatic startPulse();
      active_program = 1'b0;
      run_program    = 1'b1;
      idle(1);
      run_program    = 1'b0;
   endtask

   initial begin
      logic [NCH-1:0] wr;
      int             dens;
      modelClear();
      reset          = 1'b0;
      run_program    = 1'b0;
      active_program = 1'b0;
      end_program    = 1'b0;
      fifo_wr        = '0;
      fifo_lvl       = '0;
      rd_en          = 1'b0;
      rd_addr        = '0;

      idle(2);
      checkOutput("rst_gap_cnt", int'(gap_cnt), 0);
      checkOutput("rst_sat", int'(sat_flag), 0);
      reset = 1'b1;
      for (int a = 0; a < (1 << AW); a++) applyStimulus('0, 1'b1, AW'(a));
      idle(1);

      // Gap histogram on channel 0: idle gaps of 3, 8, 9 and 200 clocks.
      active_program = 1'b1;
      writeWord(0); idle(3);
      writeWord(0); idle(8);
      writeWord(0); idle(9);
      writeWord(0); idle(200);
      writeWord(0);
      active_program = 1'b0;
      idle(1);
      readBin(0, 0, 0);  checkOutput("t2_gap_bin0", int'(rd_data), 2);
      readBin(0, 0, 1);  checkOutput("t2_gap_bin1", int'(rd_data), 1);
      readBin(0, 0, 15); checkOutput("t2_gap_bin15", int'(rd_data), 1);
      checkOutput("t2_words0", int'(words_written[31:0]), 5);

      // Divided channel 1: six strobes make three words at fill level 17.
      end_program = 1'b1; idle(1); end_program = 1'b0;
      startPulse();
      active_program = 1'b1;
      fifo_lvl[LW +: LW] = 16'd17;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(3'b010, 1'b0, '0);
         idle(2);
      end
      checkOutput("t3_words1", int'(words_written[63:32]), 3);
      readBin(1, 1, 2);  checkOutput("t3_fill_bin2", int'(rd_data), 2);

      // Saturation on channel 2 and a held gap counter on channel 0.
      fifo_lvl[2*LW +: LW] = 16'd5;
      for (int i = 0; i < 17; i++) writeWord(2);
      readBin(2, 0, 0);  checkOutput("t4_sat_bin", int'(rd_data), CNT_MAX);
      checkOutput("t4_sat_flag", int'(sat_flag[2]), 1);
      writeWord(0); idle(300);
      checkOutput("t4_gap_hold", int'(gap_cnt[GW-1:0]), GAP_MAX);
      writeWord(0);
      readBin(0, 0, 15); checkOutput("t4_gap_top_bin", int'(rd_data), 1);

      readBin(3, 0, 0);
      checkOutput("t5_bad_ch_valid", int'(rd_valid), 1);
      checkOutput("t5_bad_ch_data", int'(rd_data), 0);
      idle(1);
      checkOutput("t5_valid_drop", int'(rd_valid), 0);

      readBin(1, 1, 2);  checkOutput("t6_first_read", int'(rd_data), 2);
      readBin(1, 1, 2);
`ifdef HIST_MON_CLR_ON_READ_EN
      checkOutput("t6_second_read", int'(rd_data), 0);
`else
      checkOutput("t6_second_read", int'(rd_data), 2);
`endif
      applyStimulus(3'b010, 1'b0, '0);
      applyStimulus(3'b010, 1'b1, {2'd1, 1'b1, 4'd2});
      readBin(1, 1, 2);
`ifdef HIST_MON_CLR_ON_READ_EN
      checkOutput("t6_read_with_update", int'(rd_data), 1);
`else
      checkOutput("t6_read_with_update", int'(rd_data), 3);
`endif

      startPulse();
      readBin(2, 0, 0);  checkOutput("t4_start_bin", int'(rd_data), 0);
      checkOutput("t4_start_flag", int'(sat_flag), 0);

      // Random traffic with occasional resets, starts and program ends.
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 299) != 0);
         run_program = ($urandom_range(0, 199) == 0);
         end_program = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 49) == 0) active_program = ~active_program;
         for (int c = 0; c < NCH; c++) begin
            fifo_lvl[c*LW +: LW] = ($urandom_range(0, 9) == 0) ? LW'($urandom)
                                                               : LW'($urandom_range(0, 140));
         end
         dens = ((i / 400) % 3 == 0) ? 2 : (((i / 400) % 3 == 1) ? 10 : 60);
         for (int c = 0; c < NCH; c++) wr[c] = ($urandom_range(0, dens - 1) == 0);
         applyStimulus(wr, 1'($urandom_range(0, 1)), AW'($urandom));
      end
      reset       = 1'b1;
      run_program = 1'b0;
      end_program = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
